iter_muldiv: RTL and testbench

ITER_MULDIV -- requirements
Module: iter_muldiv

---
 rtl/muldiv_pkg.sv | 33 +++
 rtl/div_iter.sv | 79 +++++++
 rtl/iter_muldiv.sv | 143 ++++++++++++++
 tb/tb_iter_muldiv.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   op_e    : 3-bit opcode presented on iter_muldiv.op
//   state_e : sequencer states; every state except ST_IDLE reports busy
//   CNT_W   : width of the shared cycle down-counter (covers WIDTH up to 64
//             and MUL_CYCLES up to 16)
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_MSUB  = 3'd6,
    OP_MSUBU = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MUL       = 3'd1,
    ST_DIV_SETUP = 3'd2,
    ST_DIV_ITER  = 3'd3,
    ST_DIV_FIX   = 3'd4
  } state_e;

  localparam int unsigned CNT_W = 7;

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring radix-2 divider datapath.
//   clk, rst   : clock, synchronous active-high reset
//   setup      : load operand magnitudes, clear remainder (one cycle)
//   step       : produce one quotient bit (asserted WIDTH cycles)
//   is_signed  : treat dividend/divisor as two's complement
//   dividend,
//   divisor    : operands, held stable by the parent for the whole op
//   quot, rem  : sign-corrected results, valid after the last step
//   div_zero   : divisor was zero; quot is all ones, rem is the dividend
module div_iter
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             setup,
  input  logic             step,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero
);

  logic [WIDTH-1:0] q_sr, r_sr, dvs_mag, dvd_orig;
  logic             q_neg, r_neg, zero_q;
  logic [WIDTH-1:0] dvd_mag_in, dvs_mag_in;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    dvd_mag_in = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    dvs_mag_in = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    rem_sh     = {r_sr, q_sr[WIDTH-1]};
    ge         = rem_sh >= {1'b0, dvs_mag};
    // When ge holds the difference is below the divisor, so W bits suffice.
    diff       = rem_sh[WIDTH-1:0] - dvs_mag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_sr     <= '0;
      r_sr     <= '0;
      dvs_mag  <= '0;
      dvd_orig <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      zero_q   <= 1'b0;
    end else if (setup) begin
      q_sr     <= dvd_mag_in;
      r_sr     <= '0;
      dvs_mag  <= dvs_mag_in;
      dvd_orig <= dividend;
      q_neg    <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      r_neg    <= is_signed && dividend[WIDTH-1];
      zero_q   <= (divisor == '0);
    end else if (step) begin
      r_sr <= ge ? diff : rem_sh[WIDTH-1:0];
      q_sr <= {q_sr[WIDTH-2:0], ge};
    end
  end

  // Sign fix. Most-negative / -1 needs no special case: the magnitude
  // quotient 2^(W-1) already reads back as the most-negative value.
  always_comb begin
    div_zero = zero_q;
    if (zero_q) begin
      quot = '1;
      rem  = dvd_orig;
    end else begin
      quot = q_neg ? -q_sr : q_sr;
      rem  = r_neg ? -r_sr : r_sr;
    end
  end

endmodule

// File: rtl/iter_muldiv.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
//   clk, rst  : clock, synchronous active-high reset
//   start, op : launch an operation (accepted only when idle)
//   a, b      : operands; a is also the MTHI/MTLO write data
//   hilo_we,
//   hilo_sel  : direct write of a into HI (sel=1) or LO (sel=0) when idle
//   cancel    : abort an in-flight op / suppress idle-cycle actions
//   busy      : operation in flight
//   hi, lo    : HI/LO registers
//   dbz       : sticky divide-by-zero flag
module iter_muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hilo_we,
  input  logic             hilo_sel,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dbz
);

  localparam int unsigned DIV_CYCLES = WIDTH + 2;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 3);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  op_e                op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc_q, hilo_next, ax, bx, prod, mul_res;
  logic               dbz_save;
  logic [WIDTH-1:0]   div_quot, div_rem;
  logic               div_zero;

  assign busy = (state != ST_IDLE);

  // Direct write is applied before the accumulate base is captured.
  always_comb begin
    hilo_next = {hi, lo};
    if (hilo_we) begin
      if (hilo_sel) hilo_next[2*WIDTH-1:WIDTH] = a;
      else          hilo_next[WIDTH-1:0]       = a;
    end
  end

  always_comb begin
    ax   = {{WIDTH{~op_q[0] & a_q[WIDTH-1]}}, a_q};
    bx   = {{WIDTH{~op_q[0] & b_q[WIDTH-1]}}, b_q};
    prod = ax * bx;
    case (op_q)
      OP_MADD, OP_MADDU: mul_res = acc_q + prod;
      OP_MSUB, OP_MSUBU: mul_res = acc_q - prod;
      default:           mul_res = prod;
    endcase
  end

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .setup    (state == ST_DIV_SETUP),
    .step     (state == ST_DIV_ITER),
    .is_signed(op_q == OP_DIV),
    .dividend (a_q),
    .divisor  (b_q),
    .quot     (div_quot),
    .rem      (div_rem),
    .div_zero (div_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_q     <= OP_MULT;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      hi       <= '0;
      lo       <= '0;
      dbz      <= 1'b0;
      dbz_save <= 1'b0;
    end else if (cancel) begin
      // dbz was cleared on acceptance; restore it so a flush is invisible.
      if (state != ST_IDLE) dbz <= dbz_save;
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          {hi, lo} <= hilo_next;
          if (start) begin
            op_q     <= op_e'(op);
            a_q      <= a;
            b_q      <= b;
            acc_q    <= hilo_next;
            dbz_save <= dbz;
            dbz      <= 1'b0;
            if (op_is_div(op)) begin
              state <= ST_DIV_SETUP;
            end else begin
              state <= ST_MUL;
              cnt   <= MUL_LAST;
            end
          end
        end
        ST_MUL: begin
          if (cnt == '0) begin
            {hi, lo} <= mul_res;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DIV_SETUP: begin
          state <= ST_DIV_ITER;
          cnt   <= DIV_LAST;
        end
        ST_DIV_ITER: begin
          if (cnt == '0) state <= ST_DIV_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        ST_DIV_FIX: begin
          hi    <= div_rem;
          lo    <= div_quot;
          dbz   <= div_zero;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_muldiv.sv
module tb_iter_muldiv;

  localparam logic [2:0] C_MULT = 3'd0, C_MULTU = 3'd1, C_DIV = 3'd2, C_DIVU = 3'd3;
  localparam logic [2:0] C_MADD = 3'd4, C_MADDU = 3'd5, C_MSUB = 3'd6, C_MSUBU = 3'd7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        rst, start, hilo_we, hilo_sel, cancel, busy, dbz;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo;
  // 8-bit instance, single-cycle multiply
  logic        rst8, start8, hilo_we8, hilo_sel8, cancel8, busy8, dbz8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  int total = 0;
  int bad   = 0;

  logic [63:0] m_hi, m_lo, m8_hi, m8_lo;
  bit          m_dbz, m8_dbz;

  iter_muldiv #(.WIDTH(32), .MUL_CYCLES(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hilo_we(hilo_we), .hilo_sel(hilo_sel), .cancel(cancel),
    .busy(busy), .hi(hi), .lo(lo), .dbz(dbz)
  );

  iter_muldiv #(.WIDTH(8), .MUL_CYCLES(1)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .op(op8), .a(a8), .b(b8),
    .hilo_we(hilo_we8), .hilo_sel(hilo_sel8), .cancel(cancel8),
    .busy(busy8), .hi(hi8), .lo(lo8), .dbz(dbz8)
  );

  // Reference: plain integer arithmetic on w-bit values held in 64 bits.
  function automatic void model(input int w, input logic [2:0] o,
                                input logic [63:0] x, input logic [63:0] y,
                                inout logic [63:0] h, inout logic [63:0] l,
                                inout bit z);
    logic [63:0] wm, m2, p, acc, r;
    longint xs, ys;
    wm = (64'd1 << w) - 64'd1;
    m2 = (w >= 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    xs = longint'(x & wm);
    ys = longint'(y & wm);
    if (o[0] == 1'b0 && x[w-1]) xs = xs - (longint'(1) << w);
    if (o[0] == 1'b0 && y[w-1]) ys = ys - (longint'(1) << w);
    if (o == C_DIV || o == C_DIVU) begin
      if (ys == 0) begin
        l = wm; h = x & wm; z = 1'b1;
      end else begin
        l = 64'(xs / ys) & wm; h = 64'(xs % ys) & wm; z = 1'b0;
      end
    end else begin
      p   = 64'(xs * ys);
      acc = (h << w) | l;
      if (o >= C_MSUB)      r = acc - p;
      else if (o >= C_MADD) r = acc + p;
      else                  r = p;
      r = r & m2;
      l = r & wm; h = (r >> w) & wm; z = 1'b0;
    end
  endfunction

  task automatic issue32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit we, input bit sel, input bit noisy, output int cyc);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1; hilo_we = we; hilo_sel = sel; cancel = 1'b0;
    @(negedge clk);
    start = 1'b0; hilo_we = 1'b0; cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      if (noisy) begin
        start = 1'($urandom); op = 3'($urandom); a = $urandom; b = $urandom;
        hilo_we = 1'($urandom); hilo_sel = 1'($urandom);
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0; hilo_we = 1'b0;
  endtask

  task automatic issue8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input bit we, input bit sel, output int cyc);
    @(negedge clk);
    op8 = o; a8 = x; b8 = y; start8 = 1'b1; hilo_we8 = we; hilo_sel8 = sel; cancel8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0; hilo_we8 = 1'b0; cyc = 0;
    while (busy8 === 1'b1 && cyc < 200) begin
      start8 = 1'($urandom); op8 = 3'($urandom); a8 = 8'($urandom);
      cyc++;
      @(negedge clk);
    end
    start8 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rst8 = 1'b1; start = 1'b1; hilo_we = 1'b1; a = '1; b = 32'd3;
    start8 = 1'b1; hilo_we8 = 1'b1; a8 = '1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi: got %h want 0", hi); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo: got %h want 0", lo); end
    total++; if (dbz !== 1'b0) begin bad++; $display("FAIL reset_dbz: got %b want 0", dbz); end
    total++; if (busy8 !== 1'b0 || hi8 !== 8'd0 || lo8 !== 8'd0 || dbz8 !== 1'b0) begin
      bad++; $display("FAIL reset_w8: got busy=%b hi=%h lo=%h dbz=%b want all 0", busy8, hi8, lo8, dbz8);
    end
    rst = 1'b0; rst8 = 1'b0; start = 1'b0; hilo_we = 1'b0; start8 = 1'b0; hilo_we8 = 1'b0;
  endtask

  task automatic test_mult_basic;
    int cyc;
    issue32(C_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, 1'b0, cyc);
    total++; if (cyc !== 5) begin bad++; $display("FAIL mult_busy_cycles: got %0d want 5", cyc); end
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    total++; if (lo !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
  endtask

  task automatic test_div_basic;
    int cyc;
    issue32(C_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0, cyc);
    total++; if (cyc !== 34) begin bad++; $display("FAIL div_busy_cycles: got %0d want 34", cyc); end
    total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo: got %h want fffffffd", lo); end
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi: got %h want ffffffff", hi); end
    total++; if (dbz !== 1'b0) begin bad++; $display("FAIL div_dbz: got %b want 0", dbz); end
  endtask

  task automatic test_dbz;
    int cyc;
    issue32(C_DIVU, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, cyc);
    total++; if (cyc !== 34) begin bad++; $display("FAIL dbz_busy_cycles: got %0d want 34", cyc); end
    total++; if (lo !== 32'hFFFF_FFFF || hi !== 32'd5) begin
      bad++; $display("FAIL dbz_result: got hi=%h lo=%h want hi=00000005 lo=ffffffff", hi, lo);
    end
    total++; if (dbz !== 1'b1) begin bad++; $display("FAIL dbz_set: got %b want 1", dbz); end
    issue32(C_MULTU, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, cyc);
    total++; if (dbz !== 1'b0) begin bad++; $display("FAIL dbz_clear: got %b want 0", dbz); end
    total++; if (lo !== 32'd6 || hi !== 32'd0) begin
      bad++; $display("FAIL multu_after_dbz: got hi=%h lo=%h want hi=0 lo=6", hi, lo);
    end
  endtask

  task automatic test_hilo_same_cycle;
    int cyc;
    @(negedge clk); hilo_we = 1'b1; hilo_sel = 1'b1; a = 32'h1234_5678;
    @(negedge clk); hilo_we = 1'b0;
    total++; if (hi !== 32'h1234_5678) begin bad++; $display("FAIL mthi: got %h want 12345678", hi); end
    @(negedge clk); hilo_we = 1'b1; hilo_sel = 1'b1; a = 32'd0;
    @(negedge clk); hilo_we = 1'b0;
    // a serves as both the LO write data and the multiplicand: 10 + 10*2.
    issue32(C_MADDU, 32'd10, 32'd2, 1'b1, 1'b0, 1'b0, cyc);
    total++; if (cyc !== 5) begin bad++; $display("FAIL madd_busy_cycles: got %0d want 5", cyc); end
    total++; if (lo !== 32'd30 || hi !== 32'd0) begin
      bad++; $display("FAIL mtlo_maddu: got hi=%h lo=%h want hi=0 lo=1e", hi, lo);
    end
  endtask

  task automatic test_cancel;
    int cyc;
    issue32(C_DIVU, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, cyc);
    @(negedge clk); hilo_we = 1'b1; hilo_sel = 1'b1; a = 32'h11;
    @(negedge clk); hilo_sel = 1'b0;
    @(negedge clk); hilo_we = 1'b0;
    op = C_DIV; a = 32'd100; b = 32'd3; start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 1;
    while (cyc < 20) begin
      if (cyc == 7) begin start = 1'b1; op = C_MULT; a = 32'd9; end
      else start = 1'b0;
      @(negedge clk); cyc++;
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_before_cancel: got %b want 1", busy); end
    cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cancel_busy: got %b want 0", busy); end
    total++; if (hi !== 32'h11 || lo !== 32'h11) begin
      bad++; $display("FAIL cancel_hilo: got hi=%h lo=%h want 11/11", hi, lo);
    end
    total++; if (dbz !== 1'b1) begin bad++; $display("FAIL cancel_dbz: got %b want 1", dbz); end
    // Cancel in the final multiply cycle beats the result write.
    @(negedge clk); op = C_MULT; a = 32'd3; b = 32'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
    total++; if (busy !== 1'b0 || lo !== 32'h11 || hi !== 32'h11) begin
      bad++; $display("FAIL cancel_final: got busy=%b hi=%h lo=%h want 0/11/11", busy, hi, lo);
    end
    // Idle cancel suppresses both start and the direct write.
    @(negedge clk); start = 1'b1; op = C_MULTU; a = 32'd9; hilo_we = 1'b1; hilo_sel = 1'b0; cancel = 1'b1;
    @(negedge clk); start = 1'b0; hilo_we = 1'b0; cancel = 1'b0;
    total++; if (busy !== 1'b0 || lo !== 32'h11) begin
      bad++; $display("FAIL idle_cancel: got busy=%b lo=%h want 0/11", busy, lo);
    end
  endtask

  task automatic test_random32;
    int cyc, kind, want_cyc;
    logic [2:0]  o;
    logic [31:0] x, y;
    bit we, sel;
    @(negedge clk); hilo_we = 1'b1; hilo_sel = 1'b1; a = $urandom; m_hi = {32'd0, a};
    @(negedge clk); hilo_sel = 1'b0; a = $urandom; m_lo = {32'd0, a};
    @(negedge clk); hilo_we = 1'b0;
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom); x = $urandom; y = $urandom;
      kind = $urandom_range(0, 9);
      if (kind == 0) y = 32'd0;
      else if (kind == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      else if (kind == 2) y = 32'($urandom_range(1, 5));
      we = ($urandom_range(0, 3) == 0); sel = 1'($urandom);
      if (we) begin
        if (sel) m_hi = {32'd0, x}; else m_lo = {32'd0, x};
      end
      model(32, o, {32'd0, x}, {32'd0, y}, m_hi, m_lo, m_dbz);
      want_cyc = (o == C_DIV || o == C_DIVU) ? 34 : 5;
      issue32(o, x, y, we, sel, 1'b1, cyc);
      total++; if (cyc !== want_cyc) begin bad++; $display("FAIL rand_cycles[%0d]: op=%0d got %0d want %0d", i, o, cyc, want_cyc); end
      total++; if (hi !== m_hi[31:0] || lo !== m_lo[31:0] || dbz !== m_dbz) begin
        bad++;
        $display("FAIL rand_result[%0d]: op=%0d a=%h b=%h got hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b",
                 i, o, x, y, hi, lo, dbz, m_hi[31:0], m_lo[31:0], m_dbz);
      end
    end
  endtask

  task automatic test_w8;
    int cyc, want_cyc;
    logic [2:0] o;
    logic [7:0] x, y;
    @(negedge clk); hilo_we8 = 1'b1; hilo_sel8 = 1'b1; a8 = 8'd0;
    @(negedge clk); hilo_we8 = 1'b0;
    issue8(C_MSUB, 8'd1, 8'd2, 1'b1, 1'b0, cyc);
    total++; if (cyc !== 1) begin bad++; $display("FAIL w8_msub_cycles: got %0d want 1", cyc); end
    total++; if ({hi8, lo8} !== 16'hFFFF) begin bad++; $display("FAIL w8_msub: got %h want ffff", {hi8, lo8}); end
    m8_hi = 64'hFF; m8_lo = 64'hFF;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom); x = 8'($urandom); y = 8'($urandom);
      if (i % 6 == 0) y = 8'd0;
      if (i % 6 == 1) begin x = 8'h80; y = 8'hFF; end
      model(8, o, {56'd0, x}, {56'd0, y}, m8_hi, m8_lo, m8_dbz);
      want_cyc = (o == C_DIV || o == C_DIVU) ? 10 : 1;
      issue8(o, x, y, 1'b0, 1'b0, cyc);
      total++; if (cyc !== want_cyc || hi8 !== m8_hi[7:0] || lo8 !== m8_lo[7:0] || dbz8 !== m8_dbz) begin
        bad++;
        $display("FAIL w8_rand[%0d]: op=%0d a=%h b=%h got cyc=%0d hi=%h lo=%h dbz=%b want cyc=%0d hi=%h lo=%h dbz=%b",
                 i, o, x, y, cyc, hi8, lo8, dbz8, want_cyc, m8_hi[7:0], m8_lo[7:0], m8_dbz);
      end
    end
    // Reset in the middle of a divide, with dbz and HI/LO non-zero beforehand.
    issue8(C_DIVU, 8'd7, 8'd0, 1'b0, 1'b0, cyc);
    @(negedge clk); op8 = C_DIV; a8 = 8'd50; b8 = 8'd7; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk); rst8 = 1'b0;
    total++; if (busy8 !== 1'b0 || hi8 !== 8'd0 || lo8 !== 8'd0 || dbz8 !== 1'b0) begin
      bad++; $display("FAIL w8_rst_mid_div: got busy=%b hi=%h lo=%h dbz=%b want all 0", busy8, hi8, lo8, dbz8);
    end
    issue8(C_MULTU, 8'd3, 8'd4, 1'b0, 1'b0, cyc);
    total++; if (cyc !== 1 || lo8 !== 8'd12 || hi8 !== 8'd0) begin
      bad++; $display("FAIL w8_after_rst: got cyc=%0d hi=%h lo=%h want 1/00/0c", cyc, hi8, lo8);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; hilo_we = 1'b0; hilo_sel = 1'b0; cancel = 1'b0;
    rst8 = 1'b0; start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; hilo_we8 = 1'b0; hilo_sel8 = 1'b0; cancel8 = 1'b0;
    test_reset;
    test_mult_basic;
    test_div_basic;
    test_dbz;
    test_hilo_same_cycle;
    test_cancel;
    test_random32;
    test_w8;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
